// File: rtl/multibit_stable_capture_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with a synchronous clear. Clear takes priority over
// increment, so a clear and an increment in the same cycle leave the count at
// zero. Once the count reaches all-ones it holds there until cleared or reset;
// it never wraps.
//
// Parameters:
//   W      counter width in bits (>= 1)
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, count returns to 0
//   inc    count up by one this cycle (ignored once saturated)
//   clr    synchronous clear to 0, wins over inc
//   cnt    current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multibit_stable_capture.sv
// -----------------------------------------------------------------------------
// multibit_stable_capture
//
// Qualifies a bus produced by a per-bit multi-bit synchronizer. Because each
// bit is synchronized on its own, a change on the source side can show up
// here spread over several cycles, with the bus passing through values that
// never existed at the source. This block only publishes a value after the
// bus has shown it for STABLE_CYCLES consecutive samples. A candidate value
// that is abandoned before it qualifies is reported as a glitch and counted.
//
// Parameters:
//   DW             bus width; must match the upstream synchronizer
//   STABLE_CYCLES  consecutive identical samples needed to accept a value (>= 1)
//   GW             width of the saturating glitch counter
//
// Ports:
//   clki          destination-domain clock
//   rstn          asynchronous active-low reset
//   sync_data_i   bus from the multi-bit synchronizer (opaque, compared whole)
//   clr_i         synchronous clear of glitch_cnt_o (wins over an increment)
//   data_o        last qualified bus value
//   data_valid_o  one-cycle pulse when data_o has just taken a new value
//   settling_o    high while a candidate value is being qualified
//   glitch_o      one-cycle pulse when a candidate has just been abandoned
//   glitch_cnt_o  saturating count of abandoned candidates
//
// Timing: a value first sampled at edge t and held is loaded into data_o at
// edge t + STABLE_CYCLES - 1; data_valid_o is high for the cycle after that
// edge. With STABLE_CYCLES == 1 every change is accepted on its first sample
// and the SETTLING state is never entered.
// -----------------------------------------------------------------------------
module multibit_stable_capture #(
  parameter int DW            = 32,
  parameter int STABLE_CYCLES = 4,
  parameter int GW            = 8
) (
  input  logic          clki,
  input  logic          rstn,
  input  logic [DW-1:0] sync_data_i,
  input  logic          clr_i,
  output logic [DW-1:0] data_o,
  output logic          data_valid_o,
  output logic          settling_o,
  output logic          glitch_o,
  output logic [GW-1:0] glitch_cnt_o
);

  // Sample counter must hold values up to STABLE_CYCLES.
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  // cnt_q == CNT_LAST means the current sample is the one that completes the
  // run (cnt_q + 1 == STABLE_CYCLES), so the candidate is accepted now.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   cand_q;
  logic [CW-1:0]   cnt_q;
  logic            glitch_inc;

  // A candidate is abandoned whenever the bus departs from it while it is
  // still being qualified, whether it returns to data_o or moves elsewhere.
  assign glitch_inc = (state_q == SETTLING) && (sync_data_i != cand_q);

  // ---------------------------------------------------------------------------
  // Qualification FSM. All outputs except the glitch count are registered
  // here so they change only on the clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      // NOTE: cand_q and cnt_q are reset along with the outputs even though
      // they are don't-care in STABLE; a reset mid-settle then leaves no stale
      // candidate behind and simulation never sees X on the compare paths.
      state_q      <= STABLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      settling_o   <= 1'b0;
      glitch_o     <= 1'b0;
    end else begin
      // NOTE: every register here uses non-blocking assignment, so the
      // comparisons below all see the pre-edge values of data_o, cand_q and
      // cnt_q regardless of statement order.
      data_valid_o <= 1'b0;
      glitch_o     <= glitch_inc;

      case (state_q)
        STABLE: begin
          if (sync_data_i != data_o) begin
            if (STABLE_CYCLES == 1) begin
              // The first differing sample already satisfies the run length.
              data_o       <= sync_data_i;
              data_valid_o <= 1'b1;
            end else begin
              cand_q     <= sync_data_i;
              cnt_q      <= CNT_ONE;
              state_q    <= SETTLING;
              settling_o <= 1'b1;
            end
          end
        end

        SETTLING: begin
          if (!glitch_inc) begin
            if (cnt_q == CNT_LAST) begin
              // cand_q always differs from data_o here: it was only ever
              // loaded from a sample that differed, and data_o has not moved
              // since, so the pulse can never announce an unchanged value.
              data_o       <= cand_q;
              data_valid_o <= 1'b1;
              cnt_q        <= '0;
              state_q      <= STABLE;
              settling_o   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (sync_data_i == data_o) begin
            // Transition fell back to the published value; nothing to report
            // on data_o, only the glitch.
            cnt_q      <= '0;
            state_q    <= STABLE;
            settling_o <= 1'b0;
          end else begin
            // Bus moved on to yet another value; restart qualification on it.
            cand_q <= sync_data_i;
            cnt_q  <= CNT_ONE;
          end
        end

        default: begin
          cnt_q      <= '0;
          state_q    <= STABLE;
          settling_o <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch counter: counts on the same edge that raises glitch_o, so the
  // updated count is visible together with the pulse.
  // ---------------------------------------------------------------------------
  sat_counter #(
    .W (GW)
  ) u_glitch_cnt (
    .clk   (clki),
    .rst_n (rstn),
    .inc   (glitch_inc),
    .clr   (clr_i),
    .cnt   (glitch_cnt_o)
  );

endmodule

// File: tb/tb_multibit_stable_capture.sv
// -----------------------------------------------------------------------------
// Bench for multibit_stable_capture. Three instances share clock and reset:
//   dut_a  DW=32, STABLE_CYCLES=4, GW=8  (main behaviour, latency, reset)
//   dut_b  DW=32, STABLE_CYCLES=4, GW=2  (glitch counter saturation / clear)
//   dut_c  DW=32, STABLE_CYCLES=1, GW=8  (single-sample acceptance)
// Stimulus pushes the expected data_valid_o / glitch_o events (value and the
// cycle they must appear in) into queues; monitors running on the falling
// edge pop and compare whenever a DUT raises one of those pulses.
// -----------------------------------------------------------------------------
module tb_multibit_stable_capture;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } data_exp_t;

  typedef struct {
    logic [7:0] cnt;
    int         cyc;
  } glitch_exp_t;

  logic          clki = 1'b0;
  logic          rstn;

  logic [DW-1:0] sync_a, sync_b, sync_c;
  logic          clr_a, clr_b, clr_c;

  logic [DW-1:0] data_a, data_b, data_c;
  logic          valid_a, valid_b, valid_c;
  logic          settl_a, settl_b, settl_c;
  logic          glitch_a, glitch_b, glitch_c;
  logic [7:0]    gcnt_a, gcnt_c;
  logic [1:0]    gcnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  data_exp_t   q_data_a[$];
  glitch_exp_t q_glitch_a[$];
  glitch_exp_t q_glitch_b[$];
  data_exp_t   q_data_c[$];

  always #5 clki = ~clki;

  // Edge counter: after posedge k (and until posedge k+1) cyc == k.
  always @(posedge clki) cyc <= cyc + 1;

  multibit_stable_capture #(.DW(DW), .STABLE_CYCLES(4), .GW(8)) dut_a (
    .clki(clki), .rstn(rstn), .sync_data_i(sync_a), .clr_i(clr_a),
    .data_o(data_a), .data_valid_o(valid_a), .settling_o(settl_a),
    .glitch_o(glitch_a), .glitch_cnt_o(gcnt_a)
  );

  multibit_stable_capture #(.DW(DW), .STABLE_CYCLES(4), .GW(2)) dut_b (
    .clki(clki), .rstn(rstn), .sync_data_i(sync_b), .clr_i(clr_b),
    .data_o(data_b), .data_valid_o(valid_b), .settling_o(settl_b),
    .glitch_o(glitch_b), .glitch_cnt_o(gcnt_b)
  );

  multibit_stable_capture #(.DW(DW), .STABLE_CYCLES(1), .GW(8)) dut_c (
    .clki(clki), .rstn(rstn), .sync_data_i(sync_c), .clr_i(clr_c),
    .data_o(data_c), .data_valid_o(valid_c), .settling_o(settl_c),
    .glitch_o(glitch_c), .glitch_cnt_o(gcnt_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present v after the next rising edge; it is first sampled one edge later.
  task automatic drive(input int which, input logic [DW-1:0] v);
    @(posedge clki);
    #1;
    case (which)
      0:       sync_a = v;
      1:       sync_b = v;
      default: sync_c = v;
    endcase
  endtask

  task automatic exp_data_a(input logic [DW-1:0] d, input int c);
    data_exp_t e;
    e.data = d;
    e.cyc  = c;
    q_data_a.push_back(e);
  endtask

  task automatic exp_glitch(input int which, input logic [7:0] n, input int c);
    glitch_exp_t e;
    e.cnt = n;
    e.cyc = c;
    if (which == 0) q_glitch_a.push_back(e);
    else            q_glitch_b.push_back(e);
  endtask

  task automatic exp_data_c(input logic [DW-1:0] d, input int c);
    data_exp_t e;
    e.data = d;
    e.cyc  = c;
    q_data_c.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clki) begin
    if (valid_a === 1'b1) begin
      if (q_data_a.size() == 0) begin
        check("a_unexpected_valid", {32'd0, data_a}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        data_exp_t e;
        e = q_data_a.pop_front();
        check("a_valid_data", {32'd0, data_a}, {32'd0, e.data});
        check("a_valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (glitch_a === 1'b1) begin
      if (q_glitch_a.size() == 0) begin
        check("a_unexpected_glitch", {56'd0, gcnt_a}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        glitch_exp_t e;
        e = q_glitch_a.pop_front();
        check("a_glitch_cnt", {56'd0, gcnt_a}, {56'd0, e.cnt});
        check("a_glitch_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clki) begin
    if (valid_b === 1'b1)
      check("b_unexpected_valid", {32'd0, data_b}, 64'hFFFF_FFFF_FFFF_FFFF);
    if (glitch_b === 1'b1) begin
      if (q_glitch_b.size() == 0) begin
        check("b_unexpected_glitch", {62'd0, gcnt_b}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        glitch_exp_t e;
        e = q_glitch_b.pop_front();
        check("b_glitch_cnt", {62'd0, gcnt_b}, {56'd0, e.cnt});
        check("b_glitch_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clki) begin
    if (valid_c === 1'b1) begin
      if (q_data_c.size() == 0) begin
        check("c_unexpected_valid", {32'd0, data_c}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        data_exp_t e;
        e = q_data_c.pop_front();
        check("c_valid_data", {32'd0, data_c}, {32'd0, e.data});
        check("c_valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (glitch_c === 1'b1 || settl_c === 1'b1)
      check("c_glitch_or_settling", {62'd0, glitch_c, settl_c}, 64'd0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rstn   = 1'b0;
    sync_a = '0; sync_b = '0; sync_c = '0;
    clr_a  = 1'b0; clr_b = 1'b0; clr_c = 1'b0;

    // Reset state
    repeat (3) @(posedge clki);
    #1;
    check("rst_data",     {32'd0, data_a}, 64'd0);
    check("rst_valid",    {63'd0, valid_a}, 64'd0);
    check("rst_settling", {63'd0, settl_a}, 64'd0);
    check("rst_glitch",   {63'd0, glitch_a}, 64'd0);
    check("rst_gcnt",     {56'd0, gcnt_a}, 64'd0);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clki);
      check("idle_settling", {63'd0, settl_a}, 64'd0);
    end
    check("idle_data", {32'd0, data_a}, 64'd0);

    // Clean update: settling after edges t..t+2, data at edge t+3
    drive(0, 32'hA5A5_0001);
    exp_data_a(32'hA5A5_0001, cyc + 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clki);
      @(negedge clki);
      check("clean_settling", {63'd0, settl_a}, 64'd1);
    end
    @(posedge clki);
    @(negedge clki);
    check("clean_settling_end", {63'd0, settl_a}, 64'd0);
    check("clean_data", {32'd0, data_a}, 64'hA5A5_0001);
    check("clean_gcnt", {56'd0, gcnt_a}, 64'd0);
    repeat (3) @(posedge clki);

    // Back to 0, then skewed bits 0 -> F0 (1 cycle) -> FF (held)
    drive(0, 32'h0);
    exp_data_a(32'h0, cyc + 4);
    repeat (6) @(posedge clki);
    drive(0, 32'h0000_00F0);
    drive(0, 32'h0000_00FF);
    exp_glitch(0, 8'd1, cyc + 1);
    exp_data_a(32'h0000_00FF, cyc + 4);
    repeat (8) @(posedge clki);
    @(negedge clki);
    check("skew_data", {32'd0, data_a}, 64'hFF);
    check("skew_gcnt", {56'd0, gcnt_a}, 64'd1);

    // Return to old value: data 0x10, bus 0x30 x2 then 0x10
    drive(0, 32'h10);
    exp_data_a(32'h10, cyc + 4);
    repeat (6) @(posedge clki);
    drive(0, 32'h30);
    drive(0, 32'h30);
    drive(0, 32'h10);
    exp_glitch(0, 8'd2, cyc + 1);
    @(posedge clki);
    @(negedge clki);
    check("ret_settling", {63'd0, settl_a}, 64'd0);
    repeat (5) @(posedge clki);
    @(negedge clki);
    check("ret_data", {32'd0, data_a}, 64'h10);
    check("ret_gcnt", {56'd0, gcnt_a}, 64'd2);

    // Mid-settle reset toward 0xDEAD
    drive(0, 32'hDEAD);
    @(posedge clki);
    #1;
    check("mid_settling_pre", {63'd0, settl_a}, 64'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_data",     {32'd0, data_a}, 64'd0);
    check("mid_rst_settling", {63'd0, settl_a}, 64'd0);
    check("mid_rst_valid",    {63'd0, valid_a}, 64'd0);
    check("mid_rst_glitch",   {63'd0, glitch_a}, 64'd0);
    check("mid_rst_gcnt",     {56'd0, gcnt_a}, 64'd0);
    repeat (2) @(posedge clki);
    #1;
    rstn = 1'b1;
    exp_data_a(32'hDEAD, cyc + 4);
    repeat (7) @(posedge clki);
    @(negedge clki);
    check("mid_data", {32'd0, data_a}, 64'hDEAD);

    // Saturation (GW=2) and clear-priority on dut_b
    drive(1, 32'd1);
    drive(1, 32'd2); exp_glitch(1, 8'd1, cyc + 1);
    drive(1, 32'd3); exp_glitch(1, 8'd2, cyc + 1);
    drive(1, 32'd4); exp_glitch(1, 8'd3, cyc + 1);
    drive(1, 32'd5); exp_glitch(1, 8'd3, cyc + 1);
    drive(1, 32'd6); exp_glitch(1, 8'd3, cyc + 1);
    drive(1, 32'd7); clr_b = 1'b1; exp_glitch(1, 8'd0, cyc + 1);
    drive(1, 32'd0); clr_b = 1'b0; exp_glitch(1, 8'd1, cyc + 1);
    repeat (4) @(posedge clki);
    @(negedge clki);
    check("sat_data", {32'd0, data_b}, 64'd0);
    check("sat_settling", {63'd0, settl_b}, 64'd0);

    // STABLE_CYCLES = 1 on dut_c
    drive(2, 32'h55);
    exp_data_c(32'h55, cyc + 1);
    repeat (3) @(posedge clki);
    drive(2, 32'h55);
    repeat (3) @(posedge clki);
    drive(2, 32'hAA);
    exp_data_c(32'hAA, cyc + 1);
    drive(2, 32'h55);
    exp_data_c(32'h55, cyc + 1);
    repeat (3) @(posedge clki);
    @(negedge clki);
    check("sc1_data", {32'd0, data_c}, 64'h55);

    // All expected events consumed
    repeat (2) @(posedge clki);
    @(negedge clki);
    check("left_data_a",   64'(q_data_a.size()), 64'd0);
    check("left_glitch_a", 64'(q_glitch_a.size()), 64'd0);
    check("left_glitch_b", 64'(q_glitch_b.size()), 64'd0);
    check("left_data_c",   64'(q_data_c.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
